// File: rtl/reg_file_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_controller_if
//  Description : Command/result bundle for reg_file_controller.
//                master : drives enable, instr_in, data_in, load_sel and
//                         observes data_out, out_valid, busy, flags.
//                slave  : the controller itself.
//  Ports       : enable[1:0]    command (11 IR load, 10 reg load, 01 exec)
//                instr_in[IW]   instruction word for IR load
//                data_in[WIDTH] register load data
//                load_sel[AW]   register index for register load
//                data_out       last ALU result
//                out_valid      one-cycle pulse when data_out updates
//                busy           high while an execute is in flight
//                flags[1:0]     {carry/borrow, zero}
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_controller_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);
    localparam int IW = 3 + 3 * AW;

    logic [1:0]       enable;
    logic [IW-1:0]    instr_in;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    load_sel;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic [1:0]       flags;

    modport master (
        output enable, instr_in, data_in, load_sel,
        input  data_out, out_valid, busy, flags
    );

    modport slave (
        input  enable, instr_in, data_in, load_sel,
        output data_out, out_valid, busy, flags
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_controller.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_controller
//  Description : Small register file with an instruction register and a
//                two-operand ALU (ADD/SUB/AND/XOR). All state updates on the
//                falling edge of clk. An execute takes IDLE -> EXEC -> WB;
//                the WB actions (result publish, optional writeback) happen
//                on the edge that leaves WB, so out_valid rises two falling
//                edges after the edge that accepted the execute.
//  Ports       : clk  - clock (falling edge active)
//                rst  - synchronous active-high reset
//                bus  - reg_file_controller_if.slave command/result bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_controller #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_controller_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam int IW = 3 + 3 * AW;

    localparam logic [1:0] C_EN_IR   = 2'b11;
    localparam logic [1:0] C_EN_LOAD = 2'b10;
    localparam logic [1:0] C_EN_EXEC = 2'b01;

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [IW-1:0]    ir_q, ir_d;

    // operands and control latched when an execute is accepted
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic             wb_q, wb_d;

    // ALU result captured in EXEC, published in WB
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    // instruction fields
    logic [1:0]    w_ir_op;
    logic [AW-1:0] w_ir_src0;
    logic [AW-1:0] w_ir_src1;
    logic [AW-1:0] w_ir_dest;
    logic          w_ir_wb;

    assign w_ir_op   = ir_q[IW-1:IW-2];
    assign w_ir_src0 = ir_q[3*AW:2*AW+1];
    assign w_ir_src1 = ir_q[2*AW:AW+1];
    assign w_ir_dest = ir_q[AW:1];
    assign w_ir_wb   = ir_q[0];

    // ALU on the latched operands
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;

    always_comb begin
        // extra MSB holds carry-out for ADD and borrow for SUB
        w_sum       = {1'b0, opa_q} + {1'b0, opb_q};
        w_diff      = {1'b0, opa_q} - {1'b0, opb_q};
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (op_q)
            C_OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            C_OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            C_OP_AND: w_alu_res = opa_q & opb_q;
            default:  w_alu_res = opa_q ^ opb_q;
        endcase
    end

    // next-state logic
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        ir_d        = ir_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        dest_d      = dest_q;
        wb_d        = wb_q;
        result_d    = result_q;
        carry_d     = carry_q;
        data_out_d  = data_out_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (bus.enable)
                    C_EN_IR:   ir_d = bus.instr_in;
                    C_EN_LOAD: regs_d[bus.load_sel] = bus.data_in;
                    C_EN_EXEC: begin
                        opa_d   = regs_q[w_ir_src0];
                        opb_d   = regs_q[w_ir_src1];
                        op_d    = w_ir_op;
                        dest_d  = w_ir_dest;
                        wb_d    = w_ir_wb;
                        state_d = S_EXEC;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                result_d = w_alu_res;
                carry_d  = w_alu_carry;
                state_d  = S_WB;
            end
            S_WB: begin
                data_out_d  = result_q;
                flags_d     = {carry_q, (result_q == '0)};
                out_valid_d = 1'b1;
                if (wb_q) begin
                    regs_d[dest_q] = result_q;
                end
                // a repeated execute of the same IR must not write back again
                ir_d[0] = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            dest_q      <= '0;
            wb_q        <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            data_out_q  <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            ir_q        <= ir_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            wb_q        <= wb_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            data_out_q  <= data_out_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_controller
//  Description : Self-checking bench for reg_file_controller. A transaction
//                level model (register array, IR, pending result with a
//                cycle countdown) predicts outputs after each falling edge;
//                a compare process checks them on every rising edge.
//                Directed scenarios pin the model with literal values, then
//                a randomized phase exercises commands, busy rejection and
//                resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_controller;
    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int AW    = 2;
    localparam int IW    = 3 + 3 * AW;
    localparam int MOD   = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_file_controller_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    reg_file_controller #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_regs [NREGS];
    logic [IW-1:0]    m_ir;
    logic [WIDTH-1:0] m_dout;
    logic [1:0]       m_flags;
    logic             m_valid;
    int               m_rem;     // edges until the pending result is published
    logic [WIDTH-1:0] p_res;
    logic [1:0]       p_flags;
    logic [AW-1:0]    p_dest;
    logic             p_wb;
    bit               m_ready = 1'b0;

    function automatic logic [IW-1:0] mk(input int op, input int s0, input int s1,
                                         input int d, input int wb);
        logic [IW-1:0] v;
        v = {op[1:0], s0[AW-1:0], s1[AW-1:0], d[AW-1:0], wb[0]};
        return v;
    endfunction

    task automatic alu(input int op, input int a, input int b,
                       output logic [WIDTH-1:0] res, output logic [1:0] fl);
        int r;
        int c;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r >= MOD) ? 1 : 0; r = r % MOD; end
            1: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            default: r = a ^ b;
        endcase
        res = r[WIDTH-1:0];
        fl  = {c[0], (r == 0)};
    endtask

    always @(negedge clk) begin : model
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_ir    = '0;
            m_dout  = '0;
            m_flags = '0;
            m_valid = 1'b0;
            m_rem   = 0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            m_valid = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_dout  = p_res;
                    m_flags = p_flags;
                    m_valid = 1'b1;
                    if (p_wb) m_regs[p_dest] = p_res;
                    m_ir[0] = 1'b0;
                end
            end else begin
                case (bus.enable)
                    2'b11: m_ir = bus.instr_in;
                    2'b10: m_regs[bus.load_sel] = bus.data_in;
                    2'b01: begin
                        alu(int'(m_ir[8:7]), int'(m_regs[m_ir[6:5]]),
                            int'(m_regs[m_ir[4:3]]), p_res, p_flags);
                        p_dest = m_ir[2:1];
                        p_wb   = m_ir[0];
                        m_rem  = 2;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin : compare
        if (m_ready) begin
            checks++;
            if (bus.data_out !== m_dout || bus.flags !== m_flags ||
                bus.out_valid !== m_valid || bus.busy !== (m_rem > 0)) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got dout=%h flags=%b valid=%b busy=%b, want dout=%h flags=%b valid=%b busy=%b",
                         $time, bus.data_out, bus.flags, bus.out_valid, bus.busy,
                         m_dout, m_flags, m_valid, (m_rem > 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [IW-1:0] ins,
                         input logic [WIDTH-1:0] d, input logic [AW-1:0] sel);
        @(posedge clk);
        bus.enable   = en;
        bus.instr_in = ins;
        bus.data_in  = d;
        bus.load_sel = sel;
    endtask

    task automatic idle();
        drive(2'b00, '0, '0, '0);
    endtask

    task automatic load_reg(input int r, input int v);
        drive(2'b10, '0, v[WIDTH-1:0], r[AW-1:0]);
    endtask

    task automatic load_ir(input logic [IW-1:0] ins);
        drive(2'b11, ins, '0, '0);
    endtask

    task automatic exec_expect(input string name, input int ed, input int ef);
        int seen;
        int got_d;
        int got_f;
        seen  = 0;
        got_d = -1;
        got_f = -1;
        drive(2'b01, '0, '0, '0);
        for (int i = 1; i <= 6; i++) begin
            idle();
            if (bus.out_valid === 1'b1) begin
                seen  = i;
                got_d = int'(bus.data_out);
                got_f = int'(bus.flags);
                break;
            end
        end
        check({name, "_latency"}, seen, 3);
        check({name, "_data"}, got_d, ed);
        check({name, "_flags"}, got_f, ef);
    endtask

    // observe a register by running AND r,r without writeback
    task automatic read_reg(input string name, input int r, input int exp);
        load_ir(mk(2, r, r, 0, 0));
        exec_expect(name, exp, (exp == 0) ? 1 : 0);
    endtask

    initial begin
        int busy_cnt;
        bus.enable   = 2'b00;
        bus.instr_in = '0;
        bus.data_in  = '0;
        bus.load_sel = '0;
        rst = 1'b1;
        idle();
        idle();
        idle();
        check("reset_data_out", int'(bus.data_out), 0);
        check("reset_flags", int'(bus.flags), 0);
        check("reset_valid_busy", int'({bus.out_valid, bus.busy}), 0);
        rst = 1'b0;

        // ADD with writeback
        load_reg(0, 8'h05);
        load_reg(1, 8'h03);
        load_ir(mk(0, 0, 1, 2, 1));
        exec_expect("add_basic", 8'h08, 2'b00);
        read_reg("add_basic_r2", 2, 8'h08);

        // ADD carry into R0, then re-execute without writeback
        load_reg(0, 8'hFF);
        load_reg(1, 8'h01);
        load_ir(mk(0, 0, 1, 0, 1));
        exec_expect("add_carry", 8'h00, 2'b11);
        exec_expect("add_reexec", 8'h01, 2'b00);
        read_reg("add_reexec_r0", 0, 8'h00);

        // SUB with borrow, no writeback
        load_reg(0, 8'h02);
        load_reg(1, 8'h03);
        load_ir(mk(1, 0, 1, 2, 0));
        exec_expect("sub_borrow", 8'hFF, 2'b10);
        read_reg("sub_r2_kept", 2, 8'h08);

        // AND
        load_reg(0, 8'hF0);
        load_reg(1, 8'h3C);
        load_ir(mk(2, 0, 1, 2, 0));
        exec_expect("and_basic", 8'h30, 2'b00);

        // register load while busy is ignored, busy lasts two cycles
        load_ir(mk(0, 0, 1, 3, 0));
        drive(2'b01, '0, '0, '0);
        busy_cnt = 0;
        drive(2'b10, '0, 8'hAA, 2'd1);
        if (bus.busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (bus.busy === 1'b1) busy_cnt++;
            else break;
        end
        check("busy_cycles", busy_cnt, 2);
        read_reg("busy_load_ignored_r1", 1, 8'h3C);

        // reset on the WB edge aborts the execute
        load_reg(0, 8'h02);
        load_reg(1, 8'h03);
        load_ir(mk(0, 0, 1, 3, 1));
        drive(2'b01, '0, '0, '0);
        idle();
        idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("abort_outputs", int'({bus.data_out, bus.flags, bus.out_valid, bus.busy}), 0);
        idle();
        check("abort_no_valid", int'(bus.out_valid), 0);
        read_reg("abort_r3", 3, 8'h00);

        // XOR with same source register
        load_reg(3, 8'h5A);
        load_ir(mk(3, 3, 3, 3, 1));
        exec_expect("xor_same", 8'h00, 2'b01);
        read_reg("xor_same_r3", 3, 8'h00);

        // randomized phase, checked by the compare process
        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            rst          = ($urandom_range(0, 59) == 0);
            bus.enable   = 2'($urandom);
            bus.instr_in = IW'($urandom);
            bus.data_in  = WIDTH'($urandom);
            bus.load_sel = AW'($urandom);
        end
        @(posedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
